// File: rtl/mem_lsu.sv
// ==== mem_lsu : byte/half/word load-store sequencer with read-modify-write for sub-word stores (rev 1.0) ====
`timescale 1ns/1ps
`default_nettype none

module mem_lsu #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  mem_we,
  input  logic [31:0]           mem_q
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           merge_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic                  w_accept;
  logic                  w_mis;
  logic [31:0]           w_shift;
  logic [31:0]           w_load_val;
  logic [31:0]           w_merged;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH+2];

  assign w_accept = (state_q == S_IDLE) && i_req;
  assign w_mis    = (i_size == 2'b11) ||
                    ((i_size == 2'b01) && i_addr[0]) ||
                    ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          if (w_mis)                 state_d = S_FAULT;
          else if (!i_we)            state_d = S_LOAD;
          else if (i_size == 2'b10)  state_d = S_WRITE;
          else                       state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_LOAD,
      S_WRITE,
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Little-endian lane select: shift the addressed lane down to bit 0, then extend.
  assign w_shift = mem_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   w_load_val = {{24{sign_q & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load_val = {{16{sign_q & w_shift[15]}}, w_shift[15:0]};
      default: w_load_val = mem_q;
    endcase
  end

  always_comb begin
    w_merged = merge_q;
    if (size_q == 2'b00)
      w_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_FAULT);
      err_q   <= (state_q == S_FAULT);
      if (w_accept) begin
        size_q  <= i_size;
        sign_q  <= i_sign;
        addr_q  <= i_addr[ADDR_WIDTH+1:0];
        wdata_q <= i_wdata;
      end
      if (state_q == S_READ) merge_q <= mem_q;
      if (state_q == S_LOAD) rdata_q <= w_load_val;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;
  assign mem_addr = addr_q[ADDR_WIDTH+1:2];
  assign mem_data = (size_q == 2'b10) ? wdata_q : w_merged;
  // Gated by reset so an in-flight write is dropped the instant reset rises.
  assign mem_we   = (state_q == S_WRITE) && !i_RST;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ==== tb_mem_lsu : scoreboard bench for mem_lsu against a byte-array memory model (rev 1.0) ====
`timescale 1ns/1ps
`default_nettype none

module tb_mem_lsu;

  localparam int AW = 10;

  logic          i_CLK = 1'b0;
  logic          i_RST = 1'b1;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [1:0]    i_size = 2'b00;
  logic          i_sign = 1'b0;
  logic [31:0]   i_addr = 32'd0;
  logic [31:0]   i_wdata = 32'd0;
  logic          o_ready, o_done, o_err;
  logic [31:0]   o_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          mem_we;
  logic [31:0]   mem_q;

  mem_lsu #(.ADDR_WIDTH(AW)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_sign(i_sign), .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 i_CLK = ~i_CLK;

  // Environment memory: synchronous write, combinational read, plus a preload port.
  logic [31:0]   mem [0:1023];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [31:0]   pl_d = 32'd0;
  assign mem_q = mem[mem_addr];
  always @(posedge i_CLK) begin
    if (mem_we)     mem[mem_addr] <= mem_data;
    else if (pl_we) mem[pl_a]     <= pl_d;
  end

  // Reference model state: memory as a flat little-endian byte array.
  logic [7:0]  ref_b [0:4095];
  logic [31:0] model_rdata = 32'd0;

  typedef struct { int cyc; logic err; logic [31:0] rdata; } done_t;
  typedef struct { int cyc; logic [AW-1:0] a; logic [31:0] d; } wr_t;
  done_t dq[$];
  wr_t   wq[$];
  done_t d_exp;
  wr_t   w_exp;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b1;

  always @(posedge i_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input int byte_addr);
    int b;
    b = byte_addr & 32'hFFC;
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  // Monitor: pops expectations whenever the DUT writes memory or signals completion.
  always @(negedge i_CLK) begin
    if (!i_RST && mon_en) begin
      if (mem_we) begin
        if (wq.size() == 0) check("unexpected_mem_we", {31'd0, mem_we}, 32'd0);
        else begin
          w_exp = wq.pop_front();
          check("wr_cycle", cyc, w_exp.cyc);
          check("wr_addr", {22'd0, mem_addr}, {22'd0, w_exp.a});
          check("wr_data", mem_data, w_exp.d);
        end
      end
      if (o_done) begin
        if (dq.size() == 0) check("unexpected_done", {31'd0, o_done}, 32'd0);
        else begin
          d_exp = dq.pop_front();
          check("done_cycle", cyc, d_exp.cyc);
          check("err", {31'd0, o_err}, {31'd0, d_exp.err});
          check("rdata", o_rdata, d_exp.rdata);
          check("ready_at_done", {31'd0, o_ready}, 32'd1);
        end
      end
    end
  end

  // Issue one request, wait for acceptance, compute expectations, then spray ignored junk.
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int guard, n, lat, base;
    logic mis;
    logic [31:0] v;
    done_t de;
    wr_t   we_e;
    @(negedge i_CLK);
    i_req = 1'b1; i_we = we; i_size = size; i_sign = sign; i_addr = addr; i_wdata = wdata;
    guard = 0;
    while (!o_ready && guard < 20) begin
      @(negedge i_CLK);
      guard++;
    end
    if (!o_ready) begin
      check("accept_timeout", {31'd0, o_ready}, 32'd1);
      i_req = 1'b0;
      return;
    end
    mis  = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = int'(addr[11:0]);
    lat  = 2;
    if (!mis && we) begin
      for (int i = 0; i < n; i++) ref_b[base+i] = wdata[8*i +: 8];
      if (n < 4) lat = 3;
      we_e.cyc = cyc + lat - 1;
      we_e.a   = addr[11:2];
      we_e.d   = word_at(base);
      wq.push_back(we_e);
    end else if (!mis) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | ({24'd0, ref_b[base+i]} << (8*i));
      if (sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      model_rdata = v;
    end
    de.cyc = cyc + lat; de.err = mis; de.rdata = model_rdata;
    dq.push_back(de);
    @(negedge i_CLK);
    i_req = 1'($urandom); i_we = 1'($urandom); i_size = 2'($urandom);
    i_sign = 1'($urandom); i_addr = $urandom; i_wdata = $urandom;
  endtask

  task automatic drain();
    int g;
    @(negedge i_CLK);
    i_req = 1'b0;
    g = 0;
    while ((dq.size() != 0 || wq.size() != 0) && g < 50) begin
      @(negedge i_CLK);
      g++;
    end
    check("drain_pending", dq.size() + wq.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    repeat (2) @(negedge i_CLK);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_done",  {31'd0, o_done},  32'd0);
    check("rst_err",   {31'd0, o_err},   32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);

    for (int i = 0; i < 1024; i++) begin
      @(negedge i_CLK);
      v = (i == 0) ? 32'h80F0_7FFF : $urandom;
      pl_we = 1'b1; pl_a = AW'(i); pl_d = v;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = v[8*k +: 8];
    end
    @(negedge i_CLK);
    pl_we = 1'b0;
    i_RST = 1'b0;

    issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h0000_00AB);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'd0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'd0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_5A5A);
    issue(1'b0, 2'b11, 1'b1, 32'h0000_0004, 32'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF);

    for (int t = 0; t < 300; t++)
      issue(1'($urandom), 2'($urandom), 1'($urandom),
            ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);
    drain();

    // Byte store interrupted by reset while its write is on the bus.
    mon_en = 1'b0;
    @(negedge i_CLK);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'b00; i_sign = 1'b0;
    i_addr = 32'h0000_0020; i_wdata = 32'h0000_0055;
    @(negedge i_CLK);
    i_req = 1'b0;
    @(negedge i_CLK);
    check("we_in_write", {31'd0, mem_we}, 32'd1);
    i_RST = 1'b1;
    #1;
    check("we_drop_on_rst", {31'd0, mem_we}, 32'd0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    #1;
    check("rst_word_unchanged", mem[8], word_at(32));
    check("post_rst_ready", {31'd0, o_ready}, 32'd1);
    check("post_rst_done",  {31'd0, o_done},  32'd0);
    check("post_rst_rdata", o_rdata, 32'd0);
    model_rdata = 32'd0;
    mon_en = 1'b1;

    issue(1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
